dircc_debug_slave_cmd_queue: RTL and testbench
==============================================

// Module: dircc_debug_slave_cmd_queue
// PURPOSE
//  System-clock side of the JTAG debug slave, generalised: synchronises the TCK-domain
//  update-IR/update-DR strobes, captures the shifted register with its IR, and queues
//  commands in a FIFO for the CPU debug logic (valid/ready), instead of one-shot
//  take_action pulses. Sits between the TCK shift-register block and the OCI break/ocimem/trace units.
// PARAMETERS
//  DATA_W       38  width of shifted data register sr / cmd_data
//  IR_W         2   virtual IR width; cmd_sel one-hot is 2**IR_W wide
//  DEPTH        4   command FIFO entries (power of 2, >=2)
//  SYNC_STAGES  2   synchroniser flops on vs_uir/vs_udr (>=2)
// PORTS
//  clk          in   1                  system clock
//  reset        in   1                  async active-high reset
//  vs_uir       in   1                  TCK-domain update-IR level (held >= SYNC_STAGES+1 clk)
//  vs_udr       in   1                  TCK-domain update-DR level (held >= SYNC_STAGES+1 clk)
//  ir_in        in   IR_W               virtual IR, stable while vs_uir high
//  sr           in   DATA_W             shifted data, stable while vs_udr high
//  cmd_valid    out  1                  FIFO head valid
//  cmd_ready    in   1                  consumer accepts head
//  cmd_ir       out  IR_W               IR of head command
//  cmd_sel      out  2**IR_W            one-hot decode of cmd_ir, gated by cmd_valid
//  cmd_data     out  DATA_W             data of head command (jdo equivalent)
//  cmd_count    out  $clog2(DEPTH+1)    entries occupied
//  overflow     out  1                  sticky: command dropped because FIFO full
//  ovf_clr      in   1                  clears overflow
// BEHAVIOUR
//  Reset: all sync flops 0, ir_latched=0, FIFO empty, cmd_valid=0, cmd_ir=0, cmd_sel=0,
//   cmd_data=0, cmd_count=0, overflow=0. Reset mid-operation discards queued commands.
//  Sync: vs_uir/vs_udr each pass SYNC_STAGES flops; one extra flop gives rising-edge
//   pulses uir_p/udr_p (1 clk). Falling edges ignored. Edge detect on final sync stage.
//  uir_p: ir_latched <= ir_in (sampled from the synchronized cycle).
//  udr_p: push {ir_eff, sr}; ir_eff = ir_in if uir_p same cycle, else ir_latched.
//  Push latency: vs_udr rise -> cmd_valid high after SYNC_STAGES+2 clk (FIFO empty).
//  Pop: cmd_valid && cmd_ready at clk edge advances head; outputs show next entry
//   next cycle (registered head, first-word-fall-through).
//  Simultaneous push+pop: count unchanged; allowed when full (pop frees slot, push
//   accepted, no overflow) and when empty (push only; cmd_valid rises next cycle).
//  Full + udr_p w/o pop: command dropped, FIFO untouched, overflow <= 1.
//  ovf_clr: overflow <= 0, unless a drop occurs same cycle (set wins).
//  Pointers wrap mod DEPTH; cmd_count in 0..DEPTH.
//  cmd_data/cmd_ir hold last value when cmd_valid=0 (don't-care for consumer); cmd_sel=0.
//  vs_udr held high across many clk produces exactly one push.
// TESTING
//  T1 reset, ir_in=2'd1 uir, sr=38'h2A_DEAD_BEEF udr -> cmd_valid at SYNC_STAGES+2 clk,
//     cmd_ir=1, cmd_sel=4'b0010, cmd_data=38'h2A_DEAD_BEEF, count=1; ready -> count=0.
//  T2 cmd_ready=0, 5 udr strobes data 1..5, DEPTH=4 -> count=4, overflow=1, pop
//     order 1,2,3,4; ovf_clr -> overflow=0.
//  T3 full FIFO, udr_p coincident with pop -> no overflow, count stays 4, new entry last.
//  T4 uir and udr rise same clk with ir_in=3, ir_latched=0 -> queued cmd_ir=3.
//  T5 assert reset with 3 queued -> cmd_valid=0, count=0 immediately (async); later
//     strobe queues normally.
//  T6 vs_udr held high 20 clk -> single push; ovf_clr with coincident drop -> overflow=1.

Source files
------------

// File: rtl/dircc_debug_slave_cmd_queue_if.sv
// Command-queue bundle: TCK-side strobes/data in, queued debug commands out to the CPU debug logic.
interface dircc_debug_slave_cmd_queue_if #(
  parameter int DATA_W = 38,
  parameter int IR_W   = 2,
  parameter int DEPTH  = 4
);
  localparam int SEL_W = 2**IR_W;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic              vs_uir;
  logic              vs_udr;
  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [SEL_W-1:0]  cmd_sel;
  logic [DATA_W-1:0] cmd_data;
  logic [CNT_W-1:0]  cmd_count;
  logic              overflow;
  logic              ovf_clr;

  modport master (
    output vs_uir, vs_udr, ir_in, sr, cmd_ready, ovf_clr,
    input  cmd_valid, cmd_ir, cmd_sel, cmd_data, cmd_count, overflow
  );

  modport slave (
    input  vs_uir, vs_udr, ir_in, sr, cmd_ready, ovf_clr,
    output cmd_valid, cmd_ir, cmd_sel, cmd_data, cmd_count, overflow
  );
endinterface

// File: rtl/dircc_debug_slave_cmd_queue.sv
// System-clock side of the JTAG debug slave: synchronises update-IR/DR strobes and
// queues {IR, data} commands in a FIFO presented through a registered FWFT head.
module dircc_debug_slave_cmd_queue #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                          clk_i,
  input logic                          reset_i,
  dircc_debug_slave_cmd_queue_if.slave bus
);
  localparam int SEL_W = 2**IR_W;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = IR_W + DATA_W;

  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic                   uir_last_q, udr_last_q;
  logic                   uir_p, udr_p;
  logic [IR_W-1:0]        ir_latched_q, ir_latched_d, ir_eff;
  logic [ENT_W-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d, remain;
  logic                   valid_q, valid_d;
  logic [ENT_W-1:0]       head_q, head_d;
  logic                   overflow_q, overflow_d;
  logic                   full, push, pop, drop;

  always_comb begin
    uir_sync_d   = {uir_sync_q[SYNC_STAGES-2:0], bus.vs_uir};
    udr_sync_d   = {udr_sync_q[SYNC_STAGES-2:0], bus.vs_udr};
    uir_p        = uir_sync_q[SYNC_STAGES-1] & ~uir_last_q;
    udr_p        = udr_sync_q[SYNC_STAGES-1] & ~udr_last_q;
    ir_eff       = uir_p ? bus.ir_in : ir_latched_q;
    ir_latched_d = ir_eff;

    pop  = valid_q & bus.cmd_ready;
    full = (count_q == CNT_W'(DEPTH));
    push = udr_p & (~full | pop);
    drop = udr_p & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // Only entries already in storage may reach the head; a fresh push shows one cycle later.
    remain  = count_q - CNT_W'(pop);
    valid_d = (remain != '0);
    head_d  = valid_d ? mem_q[rd_ptr_d] : head_q;

    overflow_d = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      uir_sync_q   <= '0;
      udr_sync_q   <= '0;
      uir_last_q   <= 1'b0;
      udr_last_q   <= 1'b0;
      ir_latched_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      head_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      uir_sync_q   <= uir_sync_d;
      udr_sync_q   <= udr_sync_d;
      uir_last_q   <= uir_sync_q[SYNC_STAGES-1];
      udr_last_q   <= udr_sync_q[SYNC_STAGES-1];
      ir_latched_q <= ir_latched_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      head_q       <= head_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {ir_eff, bus.sr};
  end

  assign bus.cmd_valid = valid_q;
  assign bus.cmd_ir    = head_q[ENT_W-1 -: IR_W];
  assign bus.cmd_data  = head_q[DATA_W-1:0];
  assign bus.cmd_sel   = valid_q ? (SEL_W'(1) << head_q[ENT_W-1 -: IR_W]) : '0;
  assign bus.cmd_count = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_dircc_debug_slave_cmd_queue.sv
// Bench for the debug-slave command queue: directed strobes feed a scoreboard,
// an independent monitor checks every accepted head against it.
module tb_dircc_debug_slave_cmd_queue;
  localparam int DATA_W      = 38;
  localparam int IR_W        = 2;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  dircc_debug_slave_cmd_queue_if #(.DATA_W(DATA_W), .IR_W(IR_W), .DEPTH(DEPTH)) bus ();

  dircc_debug_slave_cmd_queue #(
    .DATA_W(DATA_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  cmd_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic expect_cmd(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d);
    cmd_t e;
    e.ir   = ir;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_uir(input logic [IR_W-1:0] ir);
    bus.ir_in  = ir;
    bus.vs_uir = 1'b1;
    tick(SYNC_STAGES + 2);
    bus.vs_uir = 1'b0;
    tick(SYNC_STAGES + 2);
  endtask

  task automatic do_udr(input logic [DATA_W-1:0] d, input logic [IR_W-1:0] ir, input bit pushed);
    bus.sr = d;
    if (pushed) expect_cmd(ir, d);
    bus.vs_udr = 1'b1;
    tick(SYNC_STAGES + 2);
    bus.vs_udr = 1'b0;
    tick(SYNC_STAGES + 2);
  endtask

  task automatic drain(input int n);
    bus.cmd_ready = 1'b1;
    tick(n);
    bus.cmd_ready = 1'b0;
  endtask

  // Monitor: every head accepted (valid && ready before the edge) must match the scoreboard front.
  initial begin
    cmd_t       e;
    logic [3:0] sel_exp;
    forever begin
      @(negedge clk_i);
      if (reset_i === 1'b0 && bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got data 0x%0h with no command expected", bus.cmd_data);
        end else begin
          e       = exp_q.pop_front();
          sel_exp = 4'b0001 << e.ir;
          check("pop_data", 64'(bus.cmd_data), 64'(e.data));
          check("pop_ir",   64'(bus.cmd_ir),   64'(e.ir));
          check("pop_sel",  64'(bus.cmd_sel),  64'(sel_exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.vs_uir    = 1'b0;
    bus.vs_udr    = 1'b0;
    bus.ir_in     = '0;
    bus.sr        = '0;
    bus.cmd_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    reset_i       = 1'b1;
    tick(3);
    check("rst_valid", 64'(bus.cmd_valid), 64'd0);
    check("rst_count", 64'(bus.cmd_count), 64'd0);
    check("rst_sel",   64'(bus.cmd_sel),   64'd0);
    check("rst_ir",    64'(bus.cmd_ir),    64'd0);
    check("rst_data",  64'(bus.cmd_data),  64'd0);
    check("rst_ovf",   64'(bus.overflow),  64'd0);
    reset_i = 1'b0;
    tick(2);

    // T1: single command, push latency and head decode
    do_uir(2'd1);
    bus.sr = 38'h2A_DEAD_BEEF;
    expect_cmd(2'd1, 38'h2A_DEAD_BEEF);
    bus.vs_udr = 1'b1;
    lat = 0;
    while (bus.cmd_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'(SYNC_STAGES + 2));
    check("t1_ir",    64'(bus.cmd_ir),    64'd1);
    check("t1_sel",   64'(bus.cmd_sel),   64'b0010);
    check("t1_data",  64'(bus.cmd_data),  64'h2A_DEAD_BEEF);
    check("t1_count", 64'(bus.cmd_count), 64'd1);
    bus.vs_udr = 1'b0;
    drain(1);
    check("t1_count_after_pop", 64'(bus.cmd_count), 64'd0);
    check("t1_valid_after_pop", 64'(bus.cmd_valid), 64'd0);
    check("t1_sel_after_pop",   64'(bus.cmd_sel),   64'd0);
    tick(SYNC_STAGES + 2);

    // T2: overfill, sticky overflow, FIFO order, clear
    for (int i = 1; i <= 5; i++) do_udr(DATA_W'(i), 2'd1, i <= DEPTH);
    check("t2_count_full", 64'(bus.cmd_count), 64'd4);
    check("t2_ovf_set",    64'(bus.overflow),  64'd1);
    check("t2_head",       64'(bus.cmd_data),  64'd1);
    drain(6);
    check("t2_count_drained", 64'(bus.cmd_count), 64'd0);
    check("t2_ovf_sticky",    64'(bus.overflow),  64'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t2_ovf_cleared", 64'(bus.overflow), 64'd0);

    // T3: push coincident with pop while full
    for (int i = 0; i < DEPTH; i++) do_udr(DATA_W'(16 + i), 2'd1, 1'b1);
    check("t3_count_full", 64'(bus.cmd_count), 64'd4);
    bus.sr = 38'h14;
    expect_cmd(2'd1, 38'h14);
    bus.vs_udr = 1'b1;
    tick(SYNC_STAGES);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    check("t3_count_kept", 64'(bus.cmd_count), 64'd4);
    check("t3_no_ovf",     64'(bus.overflow),  64'd0);
    check("t3_next_head",  64'(bus.cmd_data),  64'h11);
    bus.vs_udr = 1'b0;
    tick(SYNC_STAGES + 2);
    drain(6);
    check("t3_count_drained", 64'(bus.cmd_count), 64'd0);

    // T4: uir and udr together use the new IR; later udr reuses the latched IR
    do_uir(2'd0);
    bus.ir_in  = 2'd3;
    bus.sr     = 38'h33;
    expect_cmd(2'd3, 38'h33);
    bus.vs_uir = 1'b1;
    bus.vs_udr = 1'b1;
    tick(SYNC_STAGES + 2);
    bus.vs_uir = 1'b0;
    bus.vs_udr = 1'b0;
    tick(SYNC_STAGES + 2);
    bus.ir_in = 2'd0;
    do_udr(38'h34, 2'd3, 1'b1);
    check("t4_count", 64'(bus.cmd_count), 64'd2);
    drain(4);
    check("t4_count_drained", 64'(bus.cmd_count), 64'd0);

    // T5: async reset discards queued commands
    for (int i = 0; i < 3; i++) do_udr(DATA_W'(8'h50 + i), 2'd3, 1'b1);
    check("t5_count_3", 64'(bus.cmd_count), 64'd3);
    reset_i = 1'b1;
    #1;
    check("t5_rst_valid", 64'(bus.cmd_valid), 64'd0);
    check("t5_rst_count", 64'(bus.cmd_count), 64'd0);
    check("t5_rst_sel",   64'(bus.cmd_sel),   64'd0);
    exp_q.delete();
    tick(2);
    reset_i = 1'b0;
    tick();
    do_udr(38'h60, 2'd0, 1'b1);
    check("t5_requeue_count", 64'(bus.cmd_count), 64'd1);
    check("t5_requeue_ir",    64'(bus.cmd_ir),    64'd0);
    drain(3);

    // T6: long udr level gives one push; drop wins over ovf_clr
    bus.sr = 38'h70;
    expect_cmd(2'd0, 38'h70);
    bus.vs_udr = 1'b1;
    tick(20);
    check("t6_count_held", 64'(bus.cmd_count), 64'd1);
    bus.vs_udr = 1'b0;
    tick(SYNC_STAGES + 2);
    check("t6_single_push", 64'(bus.cmd_count), 64'd1);
    for (int i = 1; i < DEPTH; i++) do_udr(DATA_W'(8'h70 + i), 2'd0, 1'b1);
    check("t6_count_full", 64'(bus.cmd_count), 64'd4);
    bus.sr = 38'h75;
    bus.vs_udr = 1'b1;
    tick(SYNC_STAGES);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t6_set_wins", 64'(bus.overflow), 64'd1);
    bus.vs_udr = 1'b0;
    tick(SYNC_STAGES + 2);
    check("t6_count_after_drop", 64'(bus.cmd_count), 64'd4);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t6_ovf_cleared", 64'(bus.overflow), 64'd0);
    drain(6);
    check("final_count",    64'(bus.cmd_count), 64'd0);
    check("final_sb_empty", 64'(exp_q.size()),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
